// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM state codes, parity helper, command bytes.
// No logic; pure constants and a combinational helper function.
// Used by both the host transmitter and the keyboard receive path.
package ps2_pkg;

  // Transmit FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Common keyboard command bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one open-collector PS/2 line plus falling-edge detect.
// Latency: sync_o lags the pad by 2 cycles; fe_o is high on the cycle the synchronized level drops.
// No backpressure; free-running. Resets to the idle (high) line level so reset never yields an edge.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic fe_o
);

  logic s1_q, s2_q, prev_q;

  // Synchronize the raw line and keep one cycle of history for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fe_o   = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 bits on device clock, ACK check.
// Latency: INHIBIT_CYCLES + SETUP_CYCLES, then paced by the device clock; bounded by TIMEOUT_CYCLES.
// tx_start is ignored (not queued) while tx_busy is high; lines driven only via output enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned SETUP_CYCLES   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             clk_sync, clk_fe, dat_sync, dat_fe_unused;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [9:0]       shift_q, shift_d;
  logic             dat_oe_q, dat_oe_d;
  logic             clk_oe_q, busy_q, done_q, done_d, err_q, err_d;

  ps2_sync_edge u_clk_sync (
    .clock (clock),
    .reset (reset),
    .line_i(ps2_clk_in),
    .sync_o(clk_sync),
    .fe_o  (clk_fe)
  );

  ps2_sync_edge u_dat_sync (
    .clock (clock),
    .reset (reset),
    .line_i(ps2_dat_in),
    .sync_o(dat_sync),
    .fe_o  (dat_fe_unused)
  );

  // Next-state logic: frame sequencing, bit shifting on device clock falls, and the shared timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_start) begin
          // Frame without the start bit; the start bit is the data-low driven in REQ
          shift_d = {1'b1, odd_parity(tx_data), tx_data};
          cnt_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = ST_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 4'd0;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TO_LAST) begin
          // Timeout wins over any edge arriving in the same cycle
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (state_q == ST_SEND) begin
          if (clk_fe) begin
            if (bit_idx_q <= 4'd8) begin
              dat_oe_d  = ~shift_q[bit_idx_q];
              bit_idx_d = bit_idx_q + 4'd1;
            end else begin
              // Stop bit is a released line
              dat_oe_d  = 1'b0;
              bit_idx_d = 4'd10;
              state_d   = ST_ACK;
            end
          end
        end else if (state_q == ST_ACK) begin
          if (clk_fe) begin
            if (!dat_sync) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else begin
          if (clk_sync && dat_sync) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs follow the next state so busy drops with done/error
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      shift_q   <= '0;
      dat_oe_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      dat_oe_q  <= dat_oe_d;
      clk_oe_q  <= (state_d == ST_INHIBIT) || (state_d == ST_REQ);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 keyboard on open-collector lines.
// Directed frames, timeout, busy/reset cases, then randomized bytes and ACK behaviour.
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_pulse_cnt = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .SETUP_CYCLES  (4),
    .TIMEOUT_CYCLES(2000),
    .CNT_W         (20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // Wired-AND open-collector lines with pull-ups
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Pulse monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
      if ((tx_done || tx_error) && tx_busy) busy_pulse_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device should see it: start, data LSB first, odd parity, stop
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Keyboard model: waits for request-to-send, clocks np pulses, samples on rising edges
  task automatic dev_frame(input int np, input bit ack, output logic [10:0] bits, output bit ok);
    int n;
    n = 0;
    bits = '1;
    ok = 1'b0;
    while (!(ps2_clk_in && !ps2_dat_in) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n < 2000) begin
      ok = 1'b1;
      bits[0] = ps2_dat_in;
      repeat (20) @(negedge clock);
      for (int p = 1; p <= np; p++) begin
        dev_clk = 1'b0;
        repeat (40) @(negedge clock);
        dev_clk = 1'b1;
        if (p <= 10) bits[p] = ps2_dat_in;
        if (p == 10 && ack) dev_dat = 1'b0;
        repeat (40) @(negedge clock);
      end
      dev_dat = 1'b1;
    end
  endtask

  task automatic send_start(input logic [7:0] b);
    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  task automatic measure_phases(output int inh, output int req);
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 1000) begin
      inh++;
      @(negedge clock);
    end
    req = 0;
    while (ps2_clk_oe && ps2_dat_oe && req < 1000) begin
      req++;
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit ack, input bit mid_start);
    logic [10:0] bits;
    bit ok;
    int inh, req, n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      dev_frame(11, ack, bits, ok);
      begin
        send_start(b);
        measure_phases(inh, req);
        if (mid_start) begin
          repeat (200) @(negedge clock);
          check_val({tag, "_busy_mid"}, tx_busy, 1);
          tx_data  = 8'h00;
          tx_start = 1'b1;
          @(negedge clock);
          tx_start = 1'b0;
        end
      end
    join
    n = 0;
    while (tx_busy && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, "_idle_bound"}, (n < 4000), 1);
    @(negedge clock);
    check_val({tag, "_req_seen"}, ok, 1);
    check_val({tag, "_inhibit"}, inh, 20);
    check_val({tag, "_setup"}, req, 4);
    check_val({tag, "_bits"}, bits, expected_frame(b));
    check_val({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
    check_val({tag, "_err"}, err_cnt - e0, ack ? 0 : 1);
    check_val({tag, "_oe"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int inh, req, n, d0, e0;
    logic [7:0] rb;
    bit rack;

    repeat (3) @(negedge clock);
    check_val("rst_state", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 5'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_frame("ed", 8'hED, 1'b1, 1'b0);
    run_frame("f4", 8'hF4, 1'b1, 1'b0);
    run_frame("noack", 8'h55, 1'b0, 1'b0);

    // Device never clocks: timeout measured from clock release
    d0 = done_cnt;
    e0 = err_cnt;
    send_start(8'hF4);
    measure_phases(inh, req);
    n = 0;
    while (!tx_error && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check_val("silent_cycles", n, 2000);
    check_val("silent_oe", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
    @(negedge clock);
    check_val("silent_err", err_cnt - e0, 1);
    check_val("silent_done", done_cnt - d0, 0);

    // Start request while busy must be ignored
    run_frame("busy", 8'h3C, 1'b1, 1'b1);

    // Reset in the middle of the data bits
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      dev_frame(4, 1'b0, bits, ok);
      send_start(8'h5A);
    join
    check_val("rst_pre_busy", tx_busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check_val("rst_mid_lines", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}, 5'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_val("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    run_frame("after_rst", 8'hFF, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      run_frame("rnd", rb, rack, 1'b0);
    end

    check_val("exclusive", both_cnt, 0);
    check_val("busy_with_pulse", busy_pulse_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
